alu_op_decode_stage: RTL and testbench
======================================

# alu_op_decode_stage

Registered decode stage that drives the ALU's operand and control inputs from a fetched RV32I instruction. It decodes opcode/funct3/funct7 into the 4-bit ALU operation code, selects and muxes operand_a/operand_b, and holds the result in a valid/ready pipeline register feeding the execute stage. It sits between fetch/register-file read and the ALU, and is the producer side of the ALU control interface.

## Interface
- No parameters. XLEN is fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  RV32I instruction word
- pc  in  32  address of instr
- rs1_data  in  32  register-file read of instr[19:15]
- rs2_data  in  32  register-file read of instr[24:20]
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  registered outputs valid
- out_ready  in  1  execute stage accepts
- operand_a  out  32  ALU operand A
- operand_b  out  32  ALU operand B
- alu_control  out  4  ALU operation code
- imm  out  32  sign-extended immediate, for branch/jump target adders
- rd  out  5  destination register
- reg_write  out  1  rd is written
- is_branch  out  1  conditional branch; funct3 carried on branch_funct3
- branch_funct3  out  3  instr[14:12] of a branch
- illegal_instr  out  1  unsupported encoding

## Operation
- ALU codes: ADD 0, SUB 1, SLL 2, SRL 3, SRA 4, SLT 5, SLTU 6, AND 7, OR 8, XOR 9.
- OP (0110011): a=rs1, b=rs2; funct3 to code; funct7 0100000 is legal only with funct3 000 (SUB) and 101 (SRA); every other funct7 must be 0000000.
- OP-IMM (0010011): a=rs1, b=imm_I. SLLI requires funct7 0000000. SRLI/SRAI are selected by funct7 0000000/0100000. No SUBI.
- LOAD (0000011) / STORE (0100011): ADD, a=rs1, b=imm_I / imm_S. Store has reg_write=0.
- LUI: ADD, a=0, b=imm_U. AUIPC: ADD, a=pc, b=imm_U.
- JAL: ADD, a=pc, b=4, imm=imm_J. JALR (funct3 000): ADD, a=pc, b=4, imm=imm_I.
- BRANCH (1100011): is_branch=1, reg_write=0, a=rs1, b=rs2, imm=imm_B. BEQ/BNE use SUB (zero flag). BLT/BGE use SLT. BLTU/BGEU use SLTU. funct3 010/011 are illegal.
- Illegal handling: any other opcode or bad funct field sets illegal_instr=1, alu_control=ADD, a=b=0, reg_write=0, is_branch=0. The instruction is still transferred normally.
- reg_write=0 whenever rd=0.

## Timing
- Latency is 1 cycle. A capture happens on the edge where in_valid && in_ready.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and has no dependence on in_valid.
- out_valid next state:
  - flush=1: 0.
  - capture: 1.
  - out_ready=1: 0.
  - Otherwise it holds.
- Data registers change only on capture. They hold stable while out_valid && !out_ready.
- Simultaneous drain and capture: when out_valid && out_ready && in_valid, the new entry replaces the old one with no bubble, giving full throughput.
- Flush takes priority over everything. The held entry is dropped, nothing is captured that cycle, and out_valid=0 on the next cycle.
- Reset, asserted at any time including mid-transfer: out_valid=0 immediately. All data outputs reset to 0, so alu_control resets to ADD. in_ready=1 once rst deasserts, provided flush=0.

## Structure
- Shared package alu_pkg holds:
  - the ALU opcode localparams (ALU_ADD..ALU_XOR);
  - RV32I opcode constants;
  - funct7 constants 0000000/0100000.
- The ALU also imports alu_pkg.
- Sub-module alu_op_decoder is purely combinational: instr, pc, rs1_data, rs2_data in; all decoded fields out.
- The top level holds only the handshake and pipeline register.

## Test plan
- sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_control=1, a=10, b=3, rd=3, reg_write=1.
- srai x5,x6,4 (0x40435293), rs1=0x80000000 -> alu_control=4, b=4, illegal_instr=0. Same word with funct7=0100001 -> illegal_instr=1, alu_control=0, reg_write=0.
- bltu x1,x2,-8 (0xFE20ECE3) -> is_branch=1, alu_control=6, imm=0xFFFFFFF8, reg_write=0, branch_funct3=110.
- Back-pressure: capture add, then out_ready=0 for 3 cycles while in_valid=1 with a new instr -> in_ready=0 and outputs hold the add. When out_ready=1, the second instr appears the next cycle with no bubble.
- flush asserted with out_valid=1 and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, and the incoming instr never appears.
- rst pulsed mid-stall with out_valid=1 -> out_valid=0 and alu_control=0 before the next clock edge. After release, auipc x7,0x12345 at pc=0x100 -> a=0x100, b=0x12345000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation codes, RV32I opcode constants and the decoded-instruction record.
// Imported by the decode stage and by the ALU itself.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [3:0]  alu_control;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic [2:0]  branch_funct3;
        logic        illegal_instr;
    } decode_t;

    // Base-encoding funct3 mapping shared by OP and OP-IMM.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] funct3);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_op_decode_stage_if.sv
// Upstream handshake, flush and ALU control bundle of the decode stage.
// master is the decode stage's view; slave is the surrounding pipeline's view.
interface alu_op_decode_stage_if;
    import alu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic [2:0]  branch_funct3;
    logic        illegal_instr;

    modport master (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, operand_a, operand_b, alu_control, imm, rd,
               reg_write, is_branch, branch_funct3, illegal_instr
    );

    modport slave (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, operand_a, operand_b, alu_control, imm, rd,
               reg_write, is_branch, branch_funct3, illegal_instr
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decoder: ALU operation, operand muxing, immediate and write-back fields.
// Illegal encodings collapse to an ADD of zeros with no side effects.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output decode_t     dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] shamt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        legal;
    logic        writes;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign shamt  = {27'd0, instr[24:20]};
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'd0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec    = '0;
        legal  = 1'b1;
        writes = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.operand_a = rs1_data;
                dec.operand_b = rs2_data;
                writes        = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.alu_control = f3_to_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.alu_control = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.alu_control = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.operand_a   = rs1_data;
                dec.operand_b   = imm_i;
                dec.imm         = imm_i;
                dec.alu_control = f3_to_alu(funct3);
                writes          = 1'b1;
                // Shift-immediates carry funct7 in imm[11:5]; only the shamt is an operand.
                if (funct3 == 3'b001) begin
                    dec.operand_b = shamt;
                    if (funct7 != F7_BASE) legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    dec.operand_b = shamt;
                    if (funct7 == F7_ALT) dec.alu_control = ALU_SRA;
                    else if (funct7 != F7_BASE) legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                dec.operand_a = rs1_data;
                dec.operand_b = imm_i;
                dec.imm       = imm_i;
                writes        = 1'b1;
            end
            OPC_STORE: begin
                dec.operand_a = rs1_data;
                dec.operand_b = imm_s;
                dec.imm       = imm_s;
            end
            OPC_LUI: begin
                dec.operand_b = imm_u;
                dec.imm       = imm_u;
                writes        = 1'b1;
            end
            OPC_AUIPC: begin
                dec.operand_a = pc;
                dec.operand_b = imm_u;
                dec.imm       = imm_u;
                writes        = 1'b1;
            end
            OPC_JAL: begin
                dec.operand_a = pc;
                dec.operand_b = 32'd4;
                dec.imm       = imm_j;
                writes        = 1'b1;
            end
            OPC_JALR: begin
                dec.operand_a = pc;
                dec.operand_b = 32'd4;
                dec.imm       = imm_i;
                writes        = 1'b1;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                dec.operand_a     = rs1_data;
                dec.operand_b     = rs2_data;
                dec.imm           = imm_b;
                dec.is_branch     = 1'b1;
                dec.branch_funct3 = funct3;
                case (funct3[2:1])
                    2'b00:   dec.alu_control = ALU_SUB;
                    2'b10:   dec.alu_control = ALU_SLT;
                    2'b11:   dec.alu_control = ALU_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec    = '0;
            writes = 1'b0;
        end
        dec.rd            = instr[11:7];
        dec.illegal_instr = !legal;
        dec.reg_write     = writes && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_op_decode_stage.sv
// Registered decode stage: one-entry valid/ready pipeline register in front of the ALU.
// Flush beats capture beats drain; data only moves on capture.
module alu_op_decode_stage
    import alu_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    alu_op_decode_stage_if.master bus
);

    decode_t dec;
    decode_t held_q;
    logic    out_valid_q;
    logic    in_ready;
    logic    capture;

    alu_op_decoder u_decoder (
        .instr    (bus.instr),
        .pc       (bus.pc),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .dec      (dec)
    );

    assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign capture  = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            held_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            held_q      <= dec;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.operand_a     = held_q.operand_a;
    assign bus.operand_b     = held_q.operand_b;
    assign bus.alu_control   = held_q.alu_control;
    assign bus.imm           = held_q.imm;
    assign bus.rd            = held_q.rd;
    assign bus.reg_write     = held_q.reg_write;
    assign bus.is_branch     = held_q.is_branch;
    assign bus.branch_funct3 = held_q.branch_funct3;
    assign bus.illegal_instr = held_q.illegal_instr;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_op_decode_stage;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_op_decode_stage_if bus ();

    alu_op_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: is an entry held, and what it should contain.
    logic    exp_valid;
    decode_t exp_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic decode_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                           input logic [31:0] r1, input logic [31:0] r2);
        logic [3:0]  base_code [8] = '{4'd0, 4'd2, 4'd5, 4'd6, 4'd9, 4'd3, 4'd8, 4'd7};
        decode_t     e;
        logic [31:0] ii, is, ib, iu, ij, sh;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        ok, wr;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        sh  = 32'(i[24:20]);
        ii  = 32'($signed(i) >>> 20);
        is  = (ii & 32'hFFFF_FFE0) | 32'(i[11:7]);
        iu  = i & 32'hFFFF_F000;
        ib  = (i[31] ? 32'hFFFF_F000 : 32'h0) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
            | (32'(i[11:8]) << 1);
        ij  = (i[31] ? 32'hFFF0_0000 : 32'h0) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
            | (32'(i[30:21]) << 1);
        e   = '0;
        ok  = 1'b1;
        wr  = 1'b1;
        if (opc == 7'h33) begin
            e.operand_a = r1; e.operand_b = r2;
            if (f7 == 7'h00) e.alu_control = base_code[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu_control = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu_control = 4'd4;
            else ok = 1'b0;
        end else if (opc == 7'h13) begin
            e.operand_a = r1; e.imm = ii; e.alu_control = base_code[f3];
            e.operand_b = (f3 == 3'd1 || f3 == 3'd5) ? sh : ii;
            if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
            if (f3 == 3'd5 && f7 == 7'h20) e.alu_control = 4'd4;
            if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) ok = 1'b0;
        end else if (opc == 7'h03) begin
            e.operand_a = r1; e.operand_b = ii; e.imm = ii;
        end else if (opc == 7'h23) begin
            e.operand_a = r1; e.operand_b = is; e.imm = is; wr = 1'b0;
        end else if (opc == 7'h37) begin
            e.operand_b = iu; e.imm = iu;
        end else if (opc == 7'h17) begin
            e.operand_a = pc; e.operand_b = iu; e.imm = iu;
        end else if (opc == 7'h6F) begin
            e.operand_a = pc; e.operand_b = 4; e.imm = ij;
        end else if (opc == 7'h67) begin
            e.operand_a = pc; e.operand_b = 4; e.imm = ii; ok = (f3 == 3'd0);
        end else if (opc == 7'h63) begin
            e.operand_a = r1; e.operand_b = r2; e.imm = ib; wr = 1'b0;
            e.is_branch = 1'b1; e.branch_funct3 = f3;
            if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
            else e.alu_control = (f3 < 3'd4) ? 4'd1 : ((f3 < 3'd6) ? 4'd5 : 4'd6);
        end else begin
            ok = 1'b0;
        end
        if (!ok) e = '0;
        e.illegal_instr = !ok;
        e.rd            = i[11:7];
        e.reg_write     = ok && wr && (i[11:7] != 5'd0);
        return e;
    endfunction

    task automatic check_fields(input decode_t e);
        check("operand_a", bus.operand_a, e.operand_a);
        check("operand_b", bus.operand_b, e.operand_b);
        check("alu_control", 32'(bus.alu_control), 32'(e.alu_control));
        check("imm", bus.imm, e.imm);
        check("rd", 32'(bus.rd), 32'(e.rd));
        check("reg_write", 32'(bus.reg_write), 32'(e.reg_write));
        check("is_branch", 32'(bus.is_branch), 32'(e.is_branch));
        check("branch_funct3", 32'(bus.branch_funct3), 32'(e.branch_funct3));
        check("illegal_instr", 32'(bus.illegal_instr), 32'(e.illegal_instr));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = p;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
    endtask

    task automatic check_model();
        logic ready;
        ready = !bus.flush && (!exp_valid || bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(ready));
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) check_fields(exp_e);
    endtask

    task automatic tick();
        logic ready;
        ready = !bus.flush && (!exp_valid || bus.out_ready);
        @(posedge clk);
        if (rst) begin
            exp_valid = 1'b0;
            exp_e     = '0;
        end else if (bus.flush) begin
            exp_valid = 1'b0;
        end else if (bus.in_valid && ready) begin
            exp_valid = 1'b1;
            exp_e     = ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
        end else if (bus.out_ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl);
        drive(v, ins, p, a, b, ordy, fl);
        check_model();
        tick();
    endtask

    localparam logic [31:0] I_SUB   = 32'h4020_81B3;
    localparam logic [31:0] I_SRAI  = 32'h4043_5293;
    localparam logic [31:0] I_SRAIX = 32'h4243_5293;
    localparam logic [31:0] I_BLTU  = 32'hFE20_ECE3;
    localparam logic [31:0] I_ADD   = 32'h0031_00B3;
    localparam logic [31:0] I_AND   = 32'h0062_F233;
    localparam logic [31:0] I_AUIPC = 32'h1234_5397;
    localparam logic [6:0]  OPCS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F,
                                          7'h67, 7'h63, 7'h5B};

    initial begin
        logic [31:0] r;
        n_tests   = 0;
        n_fail    = 0;
        exp_valid = 1'b0;
        exp_e     = '0;
        rst       = 1'b1;
        bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.rs1_data = '0;
        bus.rs2_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset alu_control", 32'(bus.alu_control), 32'd0);
        check("reset operand_a", bus.operand_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        // sub x3,x1,x2
        step(1'b1, I_SUB, 32'h0, 32'd10, 32'd3, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model();
        check("sub alu_control", 32'(bus.alu_control), 32'd1);
        check("sub operand_a", bus.operand_a, 32'd10);
        check("sub operand_b", bus.operand_b, 32'd3);
        check("sub rd", 32'(bus.rd), 32'd3);
        check("sub reg_write", 32'(bus.reg_write), 32'd1);
        tick();

        // srai legal and with a bad funct7
        step(1'b1, I_SRAI, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        drive(1'b1, I_SRAIX, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        check_model();
        check("srai alu_control", 32'(bus.alu_control), 32'd4);
        check("srai operand_b", bus.operand_b, 32'd4);
        check("srai illegal", 32'(bus.illegal_instr), 32'd0);
        tick();
        drive(1'b1, I_BLTU, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        check_model();
        check("bad srai illegal", 32'(bus.illegal_instr), 32'd1);
        check("bad srai alu_control", 32'(bus.alu_control), 32'd0);
        check("bad srai reg_write", 32'(bus.reg_write), 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model();
        check("bltu is_branch", 32'(bus.is_branch), 32'd1);
        check("bltu alu_control", 32'(bus.alu_control), 32'd6);
        check("bltu imm", bus.imm, 32'hFFFF_FFF8);
        check("bltu reg_write", 32'(bus.reg_write), 32'd0);
        check("bltu funct3", 32'(bus.branch_funct3), 32'd6);
        tick();

        // Back-pressure: add held for three cycles while and waits
        step(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, I_AND, 32'h0, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0);
            check_model();
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            check("stall operand_a", bus.operand_a, 32'd5);
            check("stall alu_control", 32'(bus.alu_control), 32'd0);
            tick();
        end
        step(1'b1, I_AND, 32'h0, 32'hF0F0, 32'h0FF0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_model();
        check("no bubble out_valid", 32'(bus.out_valid), 32'd1);
        check("no bubble alu_control", 32'(bus.alu_control), 32'd7);
        tick();

        // Flush with an entry held and a new instruction offered
        drive(1'b1, I_SUB, 32'h0, 32'd1, 32'd1, 1'b0, 1'b1);
        check_model();
        check("flush in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model();
        check("after flush out_valid", 32'(bus.out_valid), 32'd0);
        tick();

        // Asynchronous reset mid-stall
        step(1'b1, I_ADD, 32'h0, 32'd9, 32'd9, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_model();
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst alu_control", 32'(bus.alu_control), 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, I_AUIPC, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_model();
        check("auipc operand_a", bus.operand_a, 32'h100);
        check("auipc operand_b", bus.operand_b, 32'h1234_5000);
        tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            r[6:0] = OPCS[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                default: ;
            endcase
            step(($urandom_range(0, 3) != 0), r, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
